// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: each channel produces a registered
// square wave and a wrap tick, with divisor updates deferred to period boundaries.
module prog_clock_divider #(
  parameter  int NUM_CH      = 8,
  parameter  int CNT_W       = 28,
  parameter  int DEFAULT_DIV = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] cout,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DEFAULT_DIV);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] active_reg;
      logic [CNT_W-1:0] shadow_reg;
      logic             pend_reg;
      logic             cout_reg;
      logic             tick_reg;
      logic             running;
      logic             wrap;
      logic             wr_hit;
      logic             xfer;

      // D-1 is only evaluated when D>=2, so the subtraction never underflows.
      assign running = en[gi] && (active_reg >= TWO);
      assign wrap    = running && (cnt_reg >= (active_reg - ONE));
      // Out-of-range indices can never equal a valid gi, so they are ignored.
      assign wr_hit  = wr_en && (wr_ch == CH_W'(gi));
      assign xfer    = pend_reg && (wrap || !running);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg    <= '0;
          active_reg <= DIV_INIT;
          shadow_reg <= DIV_INIT;
          pend_reg   <= 1'b0;
          cout_reg   <= 1'b0;
          tick_reg   <= 1'b0;
        end else begin
          if (running) begin
            cout_reg <= (cnt_reg < (active_reg >> 1));
            if (wrap) begin
              cnt_reg  <= '0;
              tick_reg <= 1'b1;
            end else begin
              cnt_reg  <= cnt_reg + ONE;
              tick_reg <= 1'b0;
            end
          end else begin
            cnt_reg  <= '0;
            cout_reg <= 1'b0;
            tick_reg <= 1'b0;
          end

          // A write landing on the wrap edge bypasses the shadow entirely.
          if (wr_hit && wrap) begin
            active_reg <= wr_div;
            shadow_reg <= wr_div;
            pend_reg   <= 1'b0;
          end else begin
            if (xfer) begin
              active_reg <= shadow_reg;
              pend_reg   <= 1'b0;
            end
            if (wr_hit) begin
              shadow_reg <= wr_div;
              pend_reg   <= 1'b1;
            end
          end
        end
      end

      assign cout[gi]    = cout_reg;
      assign tick[gi]    = tick_reg;
      assign pending[gi] = pend_reg;
    end
  endgenerate

endmodule
